// File: rtl/jtag_debug_host_shifter.sv
// JTAG host initiator: walks the TAP from clk, shifts an IR then a DR and
// returns the TDO word captured during Shift-DR. The IR scan is skipped when cached.
module jtag_debug_host_shifter #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IR_WIDTH-1:0] ir_value,
  input  logic [DR_WIDTH-1:0] dr_value,
  output logic                busy,
  output logic                done,
  output logic [DR_WIDTH-1:0] dr_capture,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int unsigned PW = $clog2(DR_WIDTH + IR_WIDTH + 8);

  localparam logic [PW-1:0] INIT_LAST = PW'(5);
  localparam logic [PW-1:0] IR_SHL    = PW'(IR_WIDTH + 3);
  localparam logic [PW-1:0] IR_UPD    = PW'(IR_WIDTH + 4);
  localparam logic [PW-1:0] IR_LAST   = PW'(IR_WIDTH + 5);
  localparam logic [PW-1:0] DR_SH0    = PW'(3);
  localparam logic [PW-1:0] DR_SHL    = PW'(DR_WIDTH + 2);
  localparam logic [PW-1:0] DR_UPD    = PW'(DR_WIDTH + 3);
  localparam logic [PW-1:0] DR_LAST   = PW'(DR_WIDTH + 4);
  localparam logic [7:0]    DIV_LAST  = 8'(TCK_DIV - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_IR_SCAN,
    ST_DR_SCAN,
    ST_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic                 act_q, act_d;
  logic                 high_q, high_d;
  logic [7:0]           div_q, div_d;
  logic [PW-1:0]        per_q, per_d;
  logic                 tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [DR_WIDTH-1:0]  cap_q, cap_d, sr_q, sr_d, dr_q, dr_d;
  logic [IR_WIDTH-1:0]  ir_q, ir_d, cache_q, cache_d;
  logic                 cvalid_q, cvalid_d;

  logic                 period_end, last_per, ir_hit;
  logic [PW-1:0]        per_inc;

  // TMS value for period p of each scan segment.
  function automatic logic tms_of(input state_e s, input logic [PW-1:0] p);
    case (s)
      ST_INIT:    return p != INIT_LAST;
      ST_IR_SCAN: return (p < PW'(2)) || (p >= IR_SHL && p <= IR_UPD);
      ST_DR_SCAN: return (p == '0) || (p >= DR_SHL && p <= DR_UPD);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic tdi_of(input state_e s, input logic [PW-1:0] p,
                                  input logic [IR_WIDTH-1:0] ir,
                                  input logic [DR_WIDTH-1:0] dr);
    logic b;
    b = 1'b0;
    if (s == ST_IR_SCAN) begin
      for (int unsigned i = 0; i < IR_WIDTH; i++)
        if (PW'(i + 4) == p) b = ir[i];
    end else if (s == ST_DR_SCAN) begin
      for (int unsigned i = 0; i < DR_WIDTH; i++)
        if (PW'(i + 3) == p) b = dr[i];
    end
    return b;
  endfunction

  assign period_end = act_q && high_q && (div_q == DIV_LAST);
  assign last_per   = (state_q == ST_INIT    && per_q == INIT_LAST) ||
                      (state_q == ST_IR_SCAN && per_q == IR_LAST)   ||
                      (state_q == ST_DR_SCAN && per_q == DR_LAST);
  assign ir_hit     = cvalid_q && (ir_value == cache_q);
  assign per_inc    = per_q + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      act_q    <= 1'b0;
      high_q   <= 1'b0;
      div_q    <= '0;
      per_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      cap_q    <= '0;
      sr_q     <= '0;
      dr_q     <= '0;
      ir_q     <= '0;
      cache_q  <= '0;
      cvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      high_q   <= high_d;
      div_q    <= div_d;
      per_q    <= per_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cap_q    <= cap_d;
      sr_q     <= sr_d;
      dr_q     <= dr_d;
      ir_q     <= ir_d;
      cache_q  <= cache_d;
      cvalid_q <= cvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    if (period_end && last_per) state_d = ST_IDLE;
      ST_IDLE:    if (start) state_d = ir_hit ? ST_DR_SCAN : ST_IR_SCAN;
      ST_IR_SCAN: if (period_end && last_per) state_d = ST_DR_SCAN;
      ST_DR_SCAN: if (period_end && last_per) state_d = ST_FINISH;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  // Period engine: a scan entered from IDLE or reset spends one setup clk
  // before its first low phase; IR_SCAN hands straight to DR_SCAN without one.
  always_comb begin
    act_d    = act_q;
    high_d   = high_q;
    div_d    = div_q;
    per_d    = per_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cap_d    = cap_q;
    sr_d     = sr_q;
    dr_d     = dr_q;
    ir_d     = ir_q;
    cache_d  = cache_q;
    cvalid_d = cvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ir_d   = ir_value;
          dr_d   = dr_value;
          busy_d = 1'b1;
          act_d  = 1'b0;
        end
      end
      ST_FINISH: done_d = 1'b0;
      default: begin
        if (!act_q) begin
          act_d  = 1'b1;
          div_d  = '0;
          high_d = 1'b0;
          per_d  = '0;
          tck_d  = 1'b0;
          tms_d  = tms_of(state_q, '0);
          tdi_d  = tdi_of(state_q, '0, ir_q, dr_q);
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!high_q) begin
            high_d = 1'b1;
            tck_d  = 1'b1;
            if (state_q == ST_DR_SCAN && per_q >= DR_SH0 && per_q <= DR_SHL)
              sr_d = {tdo, sr_q[DR_WIDTH-1:1]};
          end else begin
            high_d = 1'b0;
            tck_d  = 1'b0;
            if (!last_per) begin
              per_d = per_inc;
              tms_d = tms_of(state_q, per_inc);
              tdi_d = tdi_of(state_q, per_inc, ir_q, dr_q);
              if (state_q == ST_IR_SCAN && per_inc == IR_UPD) begin
                cache_d  = ir_q;
                cvalid_d = 1'b1;
              end
            end else begin
              per_d = '0;
              tdi_d = 1'b0;
              case (state_q)
                ST_IR_SCAN: tms_d = tms_of(ST_DR_SCAN, '0);
                ST_DR_SCAN: begin
                  act_d  = 1'b0;
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  cap_d  = sr_q;
                  tms_d  = 1'b0;
                end
                default: begin
                  act_d  = 1'b0;
                  busy_d = 1'b0;
                  tms_d  = 1'b0;
                end
              endcase
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    tck        = tck_q;
    tms        = tms_q;
    tdi        = tdi_q;
    busy       = busy_q;
    done       = done_q;
    dr_capture = cap_q;
  end

endmodule
